mem_arbiter_ctrl: RTL and testbench

//  Shares one single-port 16-bit byte-addressed memory between an I-cache fill port (read-only) and a D-cache port (fill read or writeback write).

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/mem_arb_pick.sv | 28 ++
 rtl/mem_arbiter_ctrl.sv | 153 +++++++++++++++
 tb/tb_mem_arbiter_ctrl.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory arbiter: FSM states, requester IDs
// and the counter-width helper.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, BEAT, DONE} state_t;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    // Width of a counter that must hold values 0..n-1, never narrower than 1 bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the I-cache and D-cache requesters.
// ARB_RR_EN selects round-robin on ties; otherwise D has fixed priority.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic rr_last,
    output logic gnt_valid,
    output logic gnt
);

    assign gnt_valid = i_req | d_req;

`ifdef ARB_RR_EN
    // On a tie the requester that did not win last time goes next.
    always_comb begin
        gnt = d_req ? REQ_D : REQ_I;
        if (i_req && d_req)
            gnt = (rr_last == REQ_I) ? REQ_D : REQ_I;
    end
`else
    logic unused_rr;
    assign unused_rr = rr_last;
    assign gnt       = d_req ? REQ_D : REQ_I;
`endif

endmodule

// File: rtl/mem_arbiter_ctrl.sv
// Burst arbiter sharing one single-port memory between I-cache and D-cache.
// Arbitration policy is chosen by ARB_RR_EN inside mem_arb_pick.
module mem_arbiter_ctrl
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int BURST_LEN  = 8,
    parameter int MEM_LAT    = 4
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_rvalid,
    output logic [15:0]           i_rdata,
    output logic                  i_done,
    input  logic                  d_req,
    input  logic                  d_wr,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [15:0]           d_wdata,
    output logic                  d_wpop,
    output logic                  d_rvalid,
    output logic [15:0]           d_rdata,
    output logic                  d_done,
    output logic                  mem_en,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_wdata,
    input  logic [15:0]           mem_rdata,
    output logic                  busy
);

    localparam int BEAT_W = cnt_width(BURST_LEN);
    localparam int LAT_W  = cnt_width(MEM_LAT);
    localparam int OFFS_W = $clog2(BURST_LEN) + 1;

    localparam logic [BEAT_W-1:0]     LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
    localparam logic [LAT_W-1:0]      LAT_RELOAD = LAT_W'(MEM_LAT - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE_MASK  = ~ADDR_WIDTH'((1 << OFFS_W) - 1);

    state_t                  state;
    state_t                  state_nxt;
    logic [BEAT_W-1:0]       beat;
    logic [LAT_W-1:0]        lat;
    logic                    owner;
    logic                    wr_q;
    logic                    rr_last;
    logic [ADDR_WIDTH-1:0]   base;
    logic                    gnt_valid;
    logic                    gnt;

    mem_arb_pick u_pick (
        .i_req     (i_req),
        .d_req     (d_req),
        .rr_last   (rr_last),
        .gnt_valid (gnt_valid),
        .gnt       (gnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Grant latches the burst context; the beat/lat pair then walks the burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat    <= '0;
            lat     <= '0;
            owner   <= REQ_I;
            wr_q    <= 1'b0;
            rr_last <= REQ_I;
            base    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        owner   <= gnt;
                        rr_last <= gnt;
                        base    <= ((gnt == REQ_D) ? d_addr : i_addr) & BASE_MASK;
                        wr_q    <= (gnt == REQ_D) && d_wr;
                        beat    <= '0;
                        lat     <= LAT_RELOAD;
                    end
                end
                BEAT: begin
                    if (lat != '0) begin
                        lat <= lat - LAT_W'(1);
                    end else if (beat != LAST_BEAT) begin
                        beat <= beat + BEAT_W'(1);
                        lat  <= LAT_RELOAD;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        d_wpop    = 1'b0;
        i_rvalid  = 1'b0;
        i_rdata   = '0;
        d_rvalid  = 1'b0;
        d_rdata   = '0;
        i_done    = 1'b0;
        d_done    = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_valid)
                    state_nxt = BEAT;
            end
            BEAT: begin
                mem_en   = 1'b1;
                mem_addr = base + ADDR_WIDTH'({beat, 1'b0});
                if (wr_q)
                    mem_wdata = d_wdata;
                // The last latency cycle of a beat is where data actually moves.
                if (lat == '0) begin
                    if (wr_q) begin
                        mem_wr = 1'b1;
                        d_wpop = 1'b1;
                    end else if (owner == REQ_D) begin
                        d_rvalid = 1'b1;
                        d_rdata  = mem_rdata;
                    end else begin
                        i_rvalid = 1'b1;
                        i_rdata  = mem_rdata;
                    end
                    if (beat == LAST_BEAT)
                        state_nxt = DONE;
                end
            end
            DONE: begin
                if (owner == REQ_D)
                    d_done = 1'b1;
                else
                    i_done = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Self-checking bench for mem_arbiter_ctrl: directed scenarios plus random
// requester traffic checked cycle by cycle against a burst-level reference model.
module tb_mem_arbiter_ctrl;
    import mem_arb_pkg::*;

    localparam int BL  = 8;
    localparam int ML  = 4;
    localparam int BLW = $clog2(BL);
    localparam int OCC = BL * ML;

    logic        clk = 1'b0;
    logic        rst;
    logic        fill;
    logic        i_req, d_req, d_wr;
    logic [15:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic        i_rvalid, i_done, d_wpop, d_rvalid, d_done;
    logic        mem_en, mem_wr, busy;
    logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata;

    logic        s_i_req;
    logic [15:0] s_i_addr;
    logic        s_i_rvalid, s_i_done, s_d_wpop, s_d_rvalid, s_d_done;
    logic        s_mem_en, s_mem_wr, s_busy;
    logic [15:0] s_i_rdata, s_d_rdata, s_mem_addr, s_mem_wdata;

    logic [15:0] mem     [0:32767];
    logic [15:0] ref_mem [0:32767];
    logic [15:0] wlist   [0:BL-1];
    int          pops = 0;
    int          pop_mark = 0;
    int          checks = 0;
    int          failures = 0;

    // reference model state
    logic        m_active = 1'b0;
    int          m_t = 0;
    logic        m_owner = 1'b0;
    logic        m_wr = 1'b0;
    int          m_base = 0;
    logic [15:0] m_wl [0:BL-1];
`ifdef ARB_RR_EN
    logic        m_rr = REQ_I;
`endif

    // values captured at the falling edge of the most recent tick
    logic        obs_en, obs_wr, obs_wpop, obs_irv, obs_id, obs_dd;
    logic [15:0] obs_addr, obs_ird;
    logic        obs_s_rv, obs_s_done, obs_s_busy, obs_s_en, obs_s_quiet;
    logic [15:0] obs_s_rd, obs_s_addr;

    // burst bookkeeping for directed scenarios
    int          order[$];
    logic [15:0] ird[$];
    int          n_wr, n_pop, first_irv, done_cyc, a_min, a_max;
    logic        draining = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter_ctrl #(.ADDR_WIDTH(16), .BURST_LEN(BL), .MEM_LAT(ML)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_done(i_done),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_wpop(d_wpop),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_done(d_done),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter_ctrl #(.ADDR_WIDTH(16), .BURST_LEN(1), .MEM_LAT(1)) dut_min (
        .clk(clk), .rst(rst),
        .i_req(s_i_req), .i_addr(s_i_addr), .i_rvalid(s_i_rvalid), .i_rdata(s_i_rdata), .i_done(s_i_done),
        .d_req(1'b0), .d_wr(1'b0), .d_addr(16'h0000), .d_wdata(16'h0000), .d_wpop(s_d_wpop),
        .d_rvalid(s_d_rvalid), .d_rdata(s_d_rdata), .d_done(s_d_done),
        .mem_en(s_mem_en), .mem_wr(s_mem_wr), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
        .mem_rdata(16'h1234), .busy(s_busy)
    );

    assign mem_rdata = mem[mem_addr[15:1]];

    always_comb begin
        d_wdata = 16'h0000;
        if ((pops - pop_mark) >= 0 && (pops - pop_mark) < BL)
            d_wdata = wlist[BLW'(pops - pop_mark)];
    end

    // Memory and write-FIFO environment seen by the DUT.
    always @(posedge clk) begin
        if (fill) begin
            for (int n = 0; n < 32768; n++)
                mem[15'(n)] <= 16'(n);
        end else if (mem_en && mem_wr) begin
            mem[mem_addr[15:1]] <= mem_wdata;
        end
        if (d_wpop)
            pops <= pops + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Predicts this cycle's outputs from burst position: grant at t=0,
    // beat k spans t=k*ML+1..(k+1)*ML with data moving on its last cycle, done at OCC+1.
    task automatic modelStep();
        logic        e_en, e_wr, e_wpop, e_irv, e_drv, e_id, e_dd, e_busy, w;
        logic [15:0] e_wdata, e_ird, e_drd;
        int          k, addr, a;
        e_en = 0; e_wr = 0; e_wpop = 0; e_irv = 0; e_drv = 0; e_id = 0; e_dd = 0; e_busy = 0;
        e_wdata = 0; e_ird = 0; e_drd = 0; addr = 0;
        if (rst) begin
            m_active = 1'b0;
`ifdef ARB_RR_EN
            m_rr = REQ_I;
`endif
        end else if (!m_active) begin
            if (i_req || d_req) begin
`ifdef ARB_RR_EN
                w = (i_req && d_req) ? (m_rr == REQ_I) : d_req;
                m_rr = w;
`else
                w = d_req;
`endif
                m_active = 1'b1;
                m_t      = 0;
                m_owner  = w;
                m_wr     = w && d_wr;
                a        = w ? int'(d_addr) : int'(i_addr);
                m_base   = a - (a % (2 * BL));
                for (int j = 0; j < BL; j++)
                    m_wl[BLW'(j)] = wlist[BLW'(j)];
            end
        end else if (m_t <= OCC) begin
            k      = (m_t - 1) / ML;
            addr   = (m_base + 2 * k) % 65536;
            e_en   = 1;
            e_busy = 1;
            if (m_wr)
                e_wdata = m_wl[BLW'(k)];
            if (m_t % ML == 0) begin
                if (m_wr) begin
                    e_wr = 1;
                    e_wpop = 1;
                    ref_mem[15'(addr / 2)] = m_wl[BLW'(k)];
                end else if (m_owner) begin
                    e_drv = 1;
                    e_drd = ref_mem[15'(addr / 2)];
                end else begin
                    e_irv = 1;
                    e_ird = ref_mem[15'(addr / 2)];
                end
            end
        end else begin
            e_busy = 1;
            if (m_owner)
                e_dd = 1;
            else
                e_id = 1;
        end
        checkOutput("busy",      busy,      e_busy);
        checkOutput("mem_en",    mem_en,    e_en);
        checkOutput("mem_wr",    mem_wr,    e_wr);
        checkOutput("mem_addr",  mem_addr,  32'(addr));
        checkOutput("mem_wdata", mem_wdata, e_wdata);
        checkOutput("d_wpop",    d_wpop,    e_wpop);
        checkOutput("i_rvalid",  i_rvalid,  e_irv);
        checkOutput("i_rdata",   i_rdata,   e_ird);
        checkOutput("d_rvalid",  d_rvalid,  e_drv);
        checkOutput("d_rdata",   d_rdata,   e_drd);
        checkOutput("i_done",    i_done,    e_id);
        checkOutput("d_done",    d_done,    e_dd);
        if (m_active && !rst) begin
            m_t++;
            if (m_t > OCC + 1)
                m_active = 1'b0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        obs_en = mem_en; obs_wr = mem_wr; obs_addr = mem_addr; obs_wpop = d_wpop;
        obs_irv = i_rvalid; obs_ird = i_rdata; obs_id = i_done; obs_dd = d_done;
        obs_s_rv = s_i_rvalid; obs_s_rd = s_i_rdata; obs_s_done = s_i_done;
        obs_s_busy = s_busy; obs_s_en = s_mem_en; obs_s_addr = s_mem_addr;
        obs_s_quiet = s_d_rvalid | s_d_done | s_d_wpop | s_mem_wr | (|s_d_rdata) | (|s_mem_wdata);
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic loadWlist(input logic [15:0] seed, input logic rnd);
        for (int j = 0; j < BL; j++)
            wlist[BLW'(j)] = rnd ? 16'($urandom) : seed + 16'(j);
        pop_mark = pops;
    endtask

    task automatic doReset();
        i_req = 0; d_req = 0; s_i_req = 0;
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    // Raises the requests, drops each after its count of bursts completes.
    task automatic runBursts(input int ni, input int nd);
        int budget;
        budget = (ni + nd) * (OCC + 2) + 10;
        order.delete(); ird.delete();
        n_wr = 0; n_pop = 0; first_irv = -1; done_cyc = -1; a_min = 65536; a_max = -1;
        i_req = (ni > 0);
        d_req = (nd > 0);
        for (int c = 0; c < budget && (ni > 0 || nd > 0); c++) begin
            tick();
            if (obs_wr) n_wr++;
            if (obs_wpop) n_pop++;
            if (obs_en) begin
                if (int'(obs_addr) < a_min) a_min = int'(obs_addr);
                if (int'(obs_addr) > a_max) a_max = int'(obs_addr);
            end
            if (obs_irv) begin
                if (first_irv < 0) first_irv = c;
                ird.push_back(obs_ird);
            end
            if (obs_id) begin
                order.push_back(0);
                if (done_cyc < 0) done_cyc = c;
                ni--;
                if (ni == 0) i_req = 0;
            end
            if (obs_dd) begin
                order.push_back(1);
                nd--;
                if (nd == 0) d_req = 0;
            end
        end
        checkOutput("burst_timeout", 32'((ni > 0) || (nd > 0)), 0);
    endtask

    // Random requester behaviour: hold until done, then drop or re-request.
    task automatic applyStimulus();
        if (i_req) begin
            if (obs_id) begin
                if (!draining && $urandom_range(1, 0) == 1) i_addr = 16'($urandom);
                else i_req = 0;
            end
        end else if (!draining && $urandom_range(3, 0) == 0) begin
            i_req = 1;
            i_addr = 16'($urandom);
        end
        if (d_req) begin
            if (obs_dd) begin
                if (!draining && $urandom_range(1, 0) == 1) begin
                    d_wr = 1'($urandom_range(1, 0));
                    d_addr = 16'($urandom);
                    loadWlist(16'h0, 1'b1);
                end else begin
                    d_req = 0;
                end
            end
        end else if (!draining && $urandom_range(3, 0) == 0) begin
            d_req = 1;
            d_wr = 1'($urandom_range(1, 0));
            d_addr = 16'($urandom);
            loadWlist(16'h0, 1'b1);
        end
    endtask

    initial begin
        int c;
        i_req = 0; d_req = 0; d_wr = 0; i_addr = 0; d_addr = 0;
        s_i_req = 0; s_i_addr = 0;
        fill = 1;
        for (int n = 0; n < 32768; n++)
            ref_mem[15'(n)] = 16'(n);
        loadWlist(16'h0, 1'b0);
        doReset();
        fill = 0;
        checkOutput("reset_busy", busy, 0);

        $display("[TB] tie: both requesters rise together");
        i_addr = 16'h0040; d_addr = 16'h0200; d_wr = 0;
        runBursts(1, 1);
        checkOutput("tie_first", 32'(order[0]), 1);
        checkOutput("tie_second", 32'(order[1]), 0);

        doReset();
        $display("[TB] tie: D keeps requesting");
        runBursts(1, 2);
`ifdef ARB_RR_EN
        checkOutput("tie2_second", 32'(order[1]), 0);
`else
        checkOutput("tie2_second", 32'(order[1]), 1);
`endif

        $display("[TB] I burst read from 0x0013");
        i_addr = 16'h0013;
        runBursts(1, 0);
        checkOutput("t1_first_beat", 32'(first_irv), 4);
        checkOutput("t1_beats", 32'(ird.size()), 8);
        for (int n = 0; n < ird.size(); n++)
            checkOutput("t1_data", ird[n], 32'(8 + n));
        checkOutput("t1_done_cyc", 32'(done_cyc), 33);
        checkOutput("t1_addr_lo", 32'(a_min), 32'h10);
        checkOutput("t1_addr_hi", 32'(a_max), 32'h1E);

        $display("[TB] D writeback to 0x0100");
        d_addr = 16'h0100; d_wr = 1;
        loadWlist(16'hA000, 1'b0);
        runBursts(0, 1);
        checkOutput("t2_wr_pulses", 32'(n_wr), 8);
        checkOutput("t2_pops", 32'(n_pop), 8);
        for (int k = 0; k < BL; k++)
            checkOutput("t2_readback", mem[15'(16'h80 + k)], 32'(16'hA000 + k));

        $display("[TB] reset during beat 3 of a D write");
        d_addr = 16'h0200; d_wr = 1;
        loadWlist(16'h5500, 1'b0);
        d_req = 1;
        for (int j = 0; j < 16; j++)
            tick();
        checkOutput("t4_wr_before", mem_wr, 1);
        #1 rst = 1;
        #1;
        checkOutput("t4_en_drop", mem_en, 0);
        checkOutput("t4_wr_drop", mem_wr, 0);
        checkOutput("t4_busy_drop", busy, 0);
        d_req = 0;
        for (int j = 0; j < 3; j++) begin
            tick();
            checkOutput("t4_no_done", obs_dd, 0);
        end
        rst = 0;
        tick();
        for (int k = 0; k < 3; k++)
            checkOutput("t4_written", mem[15'(16'h100 + k)], 32'(16'h5500 + k));
        checkOutput("t4_not_written", mem[15'(16'h103)], 32'h103);

        $display("[TB] I burst at top of address space");
        i_addr = 16'hFFF2;
        runBursts(1, 0);
        checkOutput("t5_addr_lo", 32'(a_min), 32'hFFF0);
        checkOutput("t5_addr_hi", 32'(a_max), 32'hFFFE);

        $display("[TB] single-beat, single-cycle configuration");
        s_i_addr = 16'h0005; s_i_req = 1;
        tick();
        checkOutput("s_grant_rv", obs_s_rv, 0);
        checkOutput("s_grant_busy", obs_s_busy, 0);
        tick();
        checkOutput("s_beat_rv", obs_s_rv, 1);
        checkOutput("s_beat_rd", obs_s_rd, 32'h1234);
        checkOutput("s_beat_addr", obs_s_addr, 32'h0004);
        checkOutput("s_beat_quiet", obs_s_quiet, 0);
        tick();
        checkOutput("s_done", obs_s_done, 1);
        checkOutput("s_done_en", obs_s_en, 0);
        s_i_req = 0;
        tick();
        checkOutput("s_idle_busy", obs_s_busy, 0);
        checkOutput("s_idle_done", obs_s_done, 0);

        $display("[TB] random traffic");
        obs_id = 0; obs_dd = 0;
        for (int j = 0; j < 3000; j++) begin
            applyStimulus();
            tick();
        end
        draining = 1;
        c = 0;
        while ((i_req || d_req || busy) && c < 4 * (OCC + 2)) begin
            applyStimulus();
            tick();
            c++;
        end
        checkOutput("drain_timeout", 32'(i_req || d_req || busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
